// File: rtl/cook_timer_ctrl.sv
// rtl/cook_timer_ctrl.sv - keypad entry, 1 Hz tick gating and cook/pause/done sequencing for a mm:ss BCD down-counter chain
module cook_timer_ctrl #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BEEP_SECS     = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [3:0]  digit,
  input  logic        digit_valid,
  input  logic        start,
  input  logic        stop,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic [15:0] data,
  output logic        loadn,
  output logic        en,
  output logic        mag_on,
  output logic        beep,
  output logic [2:0]  state
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = $clog2(BEEP_SECS + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BMAX = BW'(BEEP_SECS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_LOAD  = 3'd2,
    S_COOK  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         st;
  logic [15:0]    entry;
  logic [PW-1:0]  presc;
  logic [BW-1:0]  bcnt;

  logic key_ok;
  logic start_ok;
  logic sec_end;
  logic cook_exit;

  assign key_ok    = digit_valid && (digit <= 4'd9);
  assign start_ok  = start && door_closed && (entry != 16'h0000) && (entry[7:4] <= 4'd5);
  assign sec_end   = (presc == PMAX);
  assign cook_exit = timer_zero || stop || !door_closed;

  // The tick is suppressed in any cycle that leaves COOK, so the chain never counts past zero.
  assign en     = (st == S_COOK) && sec_end && !cook_exit;
  assign data   = entry;
  assign loadn  = (st != S_LOAD);
  assign mag_on = (st == S_COOK);
  assign beep   = (st == S_DONE);
  assign state  = st;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st    <= S_IDLE;
      entry <= 16'h0000;
      presc <= '0;
      bcnt  <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (!stop && key_ok) begin
            entry <= {entry[11:0], digit};
            st    <= S_SET;
          end
        end
        S_SET: begin
          if (stop) begin
            st    <= S_IDLE;
            entry <= 16'h0000;
          end else if (start) begin
            if (start_ok) st <= S_LOAD;
          end else if (key_ok) begin
            entry <= {entry[11:0], digit};
          end
        end
        S_LOAD: begin
          presc <= '0;
          st    <= S_COOK;
        end
        S_COOK: begin
          if (timer_zero) begin
            st    <= S_DONE;
            presc <= '0;
            bcnt  <= '0;
          end else if (stop || !door_closed) begin
            st <= S_PAUSE;
          end else begin
            presc <= sec_end ? '0 : presc + 1'b1;
          end
        end
        S_PAUSE: begin
          if (stop) begin
            st    <= S_IDLE;
            entry <= 16'h0000;
          end else if (start && door_closed) begin
            st <= S_COOK;
          end
        end
        S_DONE: begin
          if (stop) begin
            st    <= S_IDLE;
            entry <= 16'h0000;
          end else if (sec_end) begin
            presc <= '0;
            if (bcnt == BMAX) begin
              st    <= S_IDLE;
              entry <= 16'h0000;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// tb/tb_cook_timer_ctrl.sv - scoreboard bench for cook_timer_ctrl with a BCD down-counter chain model
module tb_cook_timer_ctrl;

  logic        clk;
  logic        clrn;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        start;
  logic        stop;
  logic        door_closed;
  logic        timer_zero;
  logic [15:0] data;
  logic        loadn;
  logic        en;
  logic        mag_on;
  logic        beep;
  logic [2:0]  state;

  cook_timer_ctrl #(.TICKS_PER_SEC(4), .BEEP_SECS(2)) dut (
    .clk(clk), .clrn(clrn), .digit(digit), .digit_valid(digit_valid),
    .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
    .data(data), .loadn(loadn), .en(en), .mag_on(mag_on), .beep(beep), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mm:ss BCD down-counter chain
  logic [15:0] chain = 16'h0000;
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r[3:0] != 0) r[3:0] = r[3:0] - 1;
    else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 0) r[7:4] = r[7:4] - 1;
      else begin
        r[7:4] = 4'd5;
        if (r[11:8] != 0) r[11:8] = r[11:8] - 1;
        else begin r[11:8] = 4'd9; r[15:12] = r[15:12] - 1; end
      end
    end
    return r;
  endfunction
  always @(posedge clk) begin
    if (!loadn) chain <= data;
    else if (en) chain <= bcd_dec(chain);
  end
  assign timer_zero = (chain == 16'h0000);

  typedef struct {
    int          cyc;
    string       name;
    logic [2:0]  st;
    logic [15:0] data;
    logic        loadn;
    logic        en;
    logic        mag;
    logic        beep;
  } exp_t;

  exp_t exp_q[$];
  int   en_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  task automatic exp_push(input int c, input string nm, input logic [2:0] st, input logic [15:0] d,
                          input logic ld, input logic e, input logic m, input logic b);
    exp_t x;
    x.cyc = c; x.name = nm; x.st = st; x.data = d; x.loadn = ld; x.en = e; x.mag = m; x.beep = b;
    exp_q.push_back(x);
  endtask

  exp_t mon_e;
  int   mon_c;
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc < cyc) chk({mon_e.name, "_missed"}, cyc, mon_e.cyc);
      else begin
        chk({mon_e.name, "_state"}, state, mon_e.st);
        chk({mon_e.name, "_data"}, data, mon_e.data);
        chk({mon_e.name, "_loadn"}, loadn, mon_e.loadn);
        chk({mon_e.name, "_en"}, en, mon_e.en);
        chk({mon_e.name, "_mag_on"}, mag_on, mon_e.mag);
        chk({mon_e.name, "_beep"}, beep, mon_e.beep);
      end
    end
    if (en === 1'b1) begin
      if (en_q.size() == 0) chk("en_unexpected", 1, 0);
      else begin
        mon_c = en_q.pop_front();
        chk("en_cycle", cyc, mon_c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit = d; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  int c0;

  initial begin
    clrn = 1'b0; digit = 4'h0; digit_valid = 1'b0; start = 1'b0; stop = 1'b0; door_closed = 1'b0;
    tick(); tick();
    exp_push(cyc, "reset", 3'd0, 16'h0000, 1, 0, 0, 0);
    tick();
    clrn = 1'b1;
    tick();

    // key entry and rejection of non-decimal keys
    key(4'hF);  exp_push(cyc, "idle_bad_key", 3'd0, 16'h0000, 1, 0, 0, 0);
    key(4'd1);  exp_push(cyc, "first_key", 3'd1, 16'h0001, 1, 0, 0, 0);
    key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    exp_push(cyc, "five_keys", 3'd1, 16'h2345, 1, 0, 0, 0);
    key(4'hA);  exp_push(cyc, "bad_key_set", 3'd1, 16'h2345, 1, 0, 0, 0);
    pulse_stop(); exp_push(cyc, "stop_set", 3'd0, 16'h0000, 1, 0, 0, 0);

    // full cook of 5 s, then beep for 2 s
    door_closed = 1'b1;
    key(4'd0);  exp_push(cyc, "key_zero", 3'd1, 16'h0000, 1, 0, 0, 0);
    key(4'd5);
    pulse_start();
    c0 = cyc + 1;
    exp_push(cyc, "load", 3'd2, 16'h0005, 0, 0, 0, 0);
    exp_push(c0, "cook_entry", 3'd3, 16'h0005, 1, 0, 1, 0);
    for (int k = 0; k < 5; k++) en_q.push_back(c0 + 3 + 4 * k);
    exp_push(c0 + 20, "zero_cycle", 3'd3, 16'h0005, 1, 0, 1, 0);
    exp_push(c0 + 21, "done_entry", 3'd5, 16'h0005, 1, 0, 0, 1);
    exp_push(c0 + 28, "done_last", 3'd5, 16'h0005, 1, 0, 0, 1);
    exp_push(c0 + 29, "done_idle", 3'd0, 16'h0000, 1, 0, 0, 0);
    repeat (30) tick();

    // rejected starts
    key(4'd7); key(4'd5); pulse_start();
    exp_push(cyc, "rej_sec_tens", 3'd1, 16'h0075, 1, 0, 0, 0);
    pulse_stop(); key(4'd0); pulse_start();
    exp_push(cyc, "rej_zero", 3'd1, 16'h0000, 1, 0, 0, 0);
    pulse_stop(); key(4'd3); key(4'd0);
    door_closed = 1'b0;
    pulse_start();
    exp_push(cyc, "rej_door", 3'd1, 16'h0030, 1, 0, 0, 0);
    pulse_stop();
    door_closed = 1'b1;

    // pause on door open with prescaler at 2, resume, then stop twice
    key(4'd1); key(4'd0); pulse_start();
    c0 = cyc + 1;
    tick(); tick(); tick();
    door_closed = 1'b0;
    exp_push(cyc, "cook_presc2", 3'd3, 16'h0010, 1, 0, 1, 0);
    tick();
    exp_push(cyc, "pause_door", 3'd4, 16'h0010, 1, 0, 0, 0);
    tick(); tick();
    door_closed = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    exp_push(cyc, "resume", 3'd3, 16'h0010, 1, 0, 1, 0);
    en_q.push_back(cyc + 1);
    tick(); tick();
    pulse_stop();
    exp_push(cyc, "pause_stop", 3'd4, 16'h0010, 1, 0, 0, 0);
    pulse_stop();
    exp_push(cyc, "pause_to_idle", 3'd0, 16'h0000, 1, 0, 0, 0);

    // stop wins over start in SET
    key(4'd2);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    exp_push(cyc, "stop_start_set", 3'd0, 16'h0000, 1, 0, 0, 0);

    // asynchronous reset mid-COOK
    key(4'd4); pulse_start();
    tick(); tick();
    #1 chk("pre_rst_mag_on", mag_on, 1);
    #1 clrn = 1'b0;
    #1;
    chk("async_rst_mag_on", mag_on, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_data", data, 0);
    chk("async_rst_loadn", loadn, 1);
    #2 clrn = 1'b1;
    tick();
    key(4'd6); exp_push(cyc, "post_rst_key", 3'd1, 16'h0006, 1, 0, 0, 0);
    key(4'd9); exp_push(cyc, "post_rst_key2", 3'd1, 16'h0069, 1, 0, 0, 0);
    tick(); tick();

    chk("exp_q_drained", exp_q.size(), 0);
    chk("en_q_drained", en_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
